// File: rtl/regfile_exec_pkg.sv
// Shared types and constants for the execute/writeback stage around the 16x8 register file.
// Pure declarations: no latency, no flow control.
package regfile_exec_pkg;

  localparam int DATA_W     = 8;
  localparam int ADDR_W     = 4;
  localparam int MUL_CYCLES = 8;
  localparam int CNT_W      = 3;

  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_LDI = 3'd1,
    OP_ADD = 3'd2,
    OP_SUB = 3'd3,
    OP_AND = 3'd4,
    OP_OR  = 3'd5,
    OP_XOR = 3'd6,
    OP_MUL = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MUL    = 2'd1,
    S_MUL_WB = 2'd2
  } state_t;

  // Ops whose result is ready in the cycle right after issue.
  function automatic logic op_is_alu(input op_t op);
    return (op != OP_NOP) && (op != OP_MUL);
  endfunction

endpackage

// File: rtl/regfile_alu.sv
// Single-cycle ALU for LDI/ADD/SUB/AND/OR/XOR; NOP and MUL yield 0.
// Purely combinational, no flow control.
module regfile_alu
  import regfile_exec_pkg::*;
(
  input  op_t               op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      OP_LDI:  result = imm;
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/regfile_exec_unit.sv
// Issue/read + execute/writeback stage: ALU ops write 1 cycle after issue, MUL 9 cycles after.
// instr_ready drops only while the shift-add multiplier iterates; the sender holds its instruction.
module regfile_exec_unit
  import regfile_exec_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic [ADDR_W-1:0] instr_rs1,
  input  logic [ADDR_W-1:0] instr_rs2,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [ADDR_W-1:0] RAA,
  output logic [ADDR_W-1:0] RAB,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] W,
  output logic [ADDR_W-1:0] WA,
  output logic              Wen,
  output logic              z_flag
);

  state_t            state;
  logic [CNT_W-1:0]  mul_cnt;
  logic [DATA_W-1:0] mul_acc;

  logic              ex_valid;
  op_t               ex_op;
  logic [ADDR_W-1:0] ex_rd;
  logic [DATA_W-1:0] ex_imm;
  logic [DATA_W-1:0] ex_opa;
  logic [DATA_W-1:0] ex_opb;

  op_t               in_op;
  logic              accept;
  logic              alu_wen;
  logic              mul_wen;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;

  assign in_op       = op_t'(instr_op);
  assign instr_ready = (state != S_MUL);
  assign accept      = instr_valid && instr_ready;
  assign RAA         = instr_rs1;
  assign RAB         = instr_rs2;

  regfile_alu u_alu (
    .op     (ex_op),
    .a      (ex_opa),
    .b      (ex_opb),
    .imm    (ex_imm),
    .result (alu_res)
  );

  // EX operands stay frozen while MUL iterates (no accept in S_MUL), so the
  // multiplier reads them directly and WB reuses ex_rd.
  assign alu_wen = ex_valid && op_is_alu(ex_op);
  assign mul_wen = (state == S_MUL_WB);
  assign Wen     = alu_wen || mul_wen;
  assign WA      = Wen ? ex_rd : '0;
  assign W       = mul_wen ? mul_acc : (alu_wen ? alu_res : '0);

  assign opa = (Wen && (WA == instr_rs1)) ? W : A;
  assign opb = (Wen && (WA == instr_rs2)) ? W : B;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      mul_cnt  <= '0;
      mul_acc  <= '0;
      ex_valid <= 1'b0;
      ex_op    <= OP_NOP;
      ex_rd    <= '0;
      ex_imm   <= '0;
      ex_opa   <= '0;
      ex_opb   <= '0;
      z_flag   <= 1'b0;
    end else begin
      ex_valid <= accept;
      if (accept) begin
        ex_op  <= in_op;
        ex_rd  <= instr_rd;
        ex_imm <= instr_imm;
        ex_opa <= opa;
        ex_opb <= opb;
      end
      if (Wen) begin
        z_flag <= (W == '0);
      end
      case (state)
        S_IDLE, S_MUL_WB: begin
          if (accept && (in_op == OP_MUL)) begin
            state   <= S_MUL;
            mul_cnt <= '0;
            mul_acc <= '0;
          end else begin
            state <= S_IDLE;
          end
        end
        S_MUL: begin
          if (ex_opb[mul_cnt]) begin
            mul_acc <= mul_acc + (ex_opa << mul_cnt);
          end
          mul_cnt <= mul_cnt + 1'b1;
          if (mul_cnt == CNT_W'(MUL_CYCLES - 1)) begin
            state <= S_MUL_WB;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_exec_unit.sv
// Bench: drives directed instruction sequences, models a sequential ISA plus write/ready timing,
// and compares every cycle; a bench-side register file serves the DUT reads.
module tb_regfile_exec_unit;
  import regfile_exec_pkg::*;

  localparam int TMAX = 1024;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [2:0] instr_op = 3'd0;
  logic [3:0] instr_rd = '0, instr_rs1 = '0, instr_rs2 = '0;
  logic [7:0] instr_imm = '0;
  logic [3:0] RAA, RAB, WA;
  logic [7:0] A, B, W;
  logic       Wen, z_flag;

  always #5 clk = ~clk;

  regfile_exec_unit dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1),
    .instr_rs2(instr_rs2), .instr_imm(instr_imm),
    .RAA(RAA), .RAB(RAB), .A(A), .B(B),
    .W(W), .WA(WA), .Wen(Wen), .z_flag(z_flag)
  );

  // Environment register file: combinational read, write at the rising edge.
  logic [7:0] rf [16];
  assign A = rf[RAA];
  assign B = rf[RAB];
  always @(posedge clk) if (Wen) rf[WA] <= W;

  int n_chk = 0;
  int n_fail = 0;
  int ecnt = 0;
  bit chk_en = 1'b0;
  always @(posedge clk) ecnt++;

  // Model: architectural registers in program order plus per-interval expectations,
  // where interval t is the time between rising edges t and t+1.
  logic [7:0] mreg [16];
  bit         exp_wen  [TMAX];
  logic [3:0] exp_wa   [TMAX];
  logic [7:0] exp_w    [TMAX];
  bit         exp_busy [TMAX];
  bit         rst_at   [TMAX];
  bit         mul_pend = 1'b0;
  int         mul_t = 0;
  logic [3:0] mul_rd = '0;
  logic [7:0] mul_old = '0;
  bit         mz = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0d: got %0h, expected %0h", name, ecnt, act, exp);
    end
  endtask

  task automatic model_issue(input int n, input op_t op, input logic [3:0] rd,
                             input logic [3:0] rs1, input logic [3:0] rs2, input logic [7:0] imm);
    logic [7:0]  a, b, res;
    logic [15:0] prod;
    int          wt;
    a = mreg[rs1];
    b = mreg[rs2];
    prod = 16'(a) * 16'(b);
    case (op)
      OP_LDI:  res = imm;
      OP_ADD:  res = 8'((9'(a) + 9'(b)) % 256);
      OP_SUB:  res = 8'((9'(a) + 9'd256 - 9'(b)) % 256);
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_MUL:  res = prod[7:0];
      default: res = 8'h00;
    endcase
    if (op == OP_NOP) return;
    wt = (op == OP_MUL) ? n + MUL_CYCLES : n;
    if (op == OP_MUL) begin
      for (int t = n; t < n + MUL_CYCLES; t++) exp_busy[t] = 1'b1;
      mul_pend = 1'b1;
      mul_t    = wt;
      mul_rd   = rd;
      mul_old  = mreg[rd];
    end
    exp_wen[wt] = 1'b1;
    exp_wa[wt]  = rd;
    exp_w[wt]   = res;
    mreg[rd]    = res;
  endtask

  // One cycle: called just after a rising edge, sets inputs for the next edge.
  task automatic cyc(input bit r, input bit v, input op_t op, input logic [3:0] rd,
                     input logic [3:0] rs1, input logic [3:0] rs2, input logic [7:0] imm,
                     output bit acc);
    int n;
    n = ecnt + 1;
    rst = r; instr_valid = v; instr_op = op;
    instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2; instr_imm = imm;
    acc = v && (instr_ready === 1'b1) && !r;
    if (r) begin
      rst_at[n] = 1'b1;
      for (int t = n; t < TMAX; t++) begin
        exp_wen[t]  = 1'b0;
        exp_busy[t] = 1'b0;
      end
      if (mul_pend && mul_t >= n) mreg[mul_rd] = mul_old;
      mul_pend = 1'b0;
    end
    if (acc) model_issue(n, op, rd, rs1, rs2, imm);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    bit acc;
    for (int i = 0; i < k; i++) cyc(1'b0, 1'b0, OP_NOP, 4'd0, 4'd0, 4'd0, 8'd0, acc);
  endtask

  task automatic iss(input op_t op, input logic [3:0] rd, input logic [3:0] rs1,
                     input logic [3:0] rs2, input logic [7:0] imm,
                     output int edge_n, output int stalls);
    bit acc;
    acc = 1'b0;
    stalls = 0;
    edge_n = -1;
    for (int i = 0; i < 20; i++) begin
      edge_n = ecnt + 1;
      cyc(1'b0, 1'b1, op, rd, rs1, rs2, imm, acc);
      if (acc) break;
      stalls++;
    end
    if (!acc) check("issue_timeout", 32'd0, 32'd1);
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en && ecnt < TMAX) begin
      if (ecnt >= 1 && exp_wen[ecnt-1]) mz = (exp_w[ecnt-1] == 8'h00);
      if (rst_at[ecnt]) mz = 1'b0;
      check("wen", Wen, exp_wen[ecnt]);
      if (exp_wen[ecnt]) begin
        check("wa", WA, exp_wa[ecnt]);
        check("w", W, exp_w[ecnt]);
      end
      check("ready", instr_ready, !exp_busy[ecnt]);
      check("z_flag", z_flag, mz);
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    int e1, e2, e3, em, ea, st, sd;
    for (int i = 0; i < 16; i++) begin
      rf[i] = 8'h00;
      mreg[i] = 8'h00;
    end

    cyc(1'b1, 1'b0, OP_NOP, 4'd0, 4'd0, 4'd0, 8'd0, acc);
    chk_en = 1'b1;
    check("rst_wen", Wen, 32'd0);
    check("rst_w", W, 32'd0);
    check("rst_wa", WA, 32'd0);
    check("rst_ready", instr_ready, 32'd1);
    check("rst_z", z_flag, 32'd0);

    // Back-to-back dependent ALU ops.
    iss(OP_LDI, 4'd1, 4'd0, 4'd0, 8'd5, e1, sd);
    iss(OP_LDI, 4'd2, 4'd0, 4'd0, 8'd3, e2, sd);
    iss(OP_ADD, 4'd3, 4'd1, 4'd2, 8'd0, e3, sd);
    idle(2);
    check("no_stall", 32'(e3 - e1), 32'd2);
    check("r3_add", rf[3], 32'h08);

    // Wraparound and zero flag.
    iss(OP_LDI, 4'd1, 4'd0, 4'd0, 8'h80, e1, sd);
    iss(OP_ADD, 4'd2, 4'd1, 4'd1, 8'd0, e2, sd);
    iss(OP_SUB, 4'd3, 4'd0, 4'd1, 8'd0, e3, sd);
    check("z_after_add", z_flag, 32'd1);
    idle(2);
    check("r2_wrap", rf[2], 32'h00);
    check("r3_sub", rf[3], 32'h80);
    check("z_after_sub", z_flag, 32'd0);

    // Multiply with a dependent op held through the stall.
    iss(OP_LDI, 4'd4, 4'd0, 4'd0, 8'd13, e1, sd);
    iss(OP_LDI, 4'd5, 4'd0, 4'd0, 8'd11, e2, sd);
    iss(OP_MUL, 4'd6, 4'd4, 4'd5, 8'd0, em, sd);
    iss(OP_ADD, 4'd7, 4'd6, 4'd6, 8'd0, ea, st);
    idle(2);
    check("mul_stall_cycles", 32'(st), 32'd8);
    check("add_after_mul", 32'(ea - em), 32'd9);
    check("r6_mul", rf[6], 32'h8F);
    check("r7_fwd_mul", rf[7], 32'h1E);

    // Reset while the multiplier is at counter 4.
    iss(OP_MUL, 4'd6, 4'd4, 4'd4, 8'd0, em, sd);
    idle(4);
    cyc(1'b1, 1'b0, OP_NOP, 4'd0, 4'd0, 4'd0, 8'd0, acc);
    idle(12);
    check("r6_after_abort", rf[6], 32'h8F);
    check("ready_after_abort", instr_ready, 32'd1);

    // Reset in the same cycle as an accept drops the instruction.
    cyc(1'b1, 1'b1, OP_LDI, 4'd1, 4'd0, 4'd0, 8'h33, acc);
    idle(3);
    check("r1_dropped", rf[1], 32'h80);

    // Valid toggling with logic ops, then NOP keeping z.
    iss(OP_LDI, 4'd11, 4'd0, 4'd0, 8'h5A, e1, sd);
    iss(OP_LDI, 4'd12, 4'd0, 4'd0, 8'h3C, e2, sd);
    iss(OP_XOR, 4'd13, 4'd11, 4'd12, 8'd0, e1, sd);
    idle(1);
    iss(OP_AND, 4'd14, 4'd11, 4'd12, 8'd0, e2, sd);
    idle(1);
    iss(OP_OR, 4'd15, 4'd11, 4'd12, 8'd0, e3, sd);
    iss(OP_XOR, 4'd8, 4'd11, 4'd11, 8'd0, e1, sd);
    iss(OP_NOP, 4'd8, 4'd11, 4'd12, 8'hFF, e2, sd);
    idle(2);
    check("r13_xor", rf[13], 32'h66);
    check("r14_and", rf[14], 32'h18);
    check("r15_or", rf[15], 32'h7E);
    check("r8_zero", rf[8], 32'h00);
    check("z_kept_by_nop", z_flag, 32'd1);

    // Both operands forwarded.
    iss(OP_LDI, 4'd9, 4'd0, 4'd0, 8'h0F, e1, sd);
    iss(OP_OR, 4'd10, 4'd9, 4'd9, 8'd0, e2, sd);
    idle(2);
    check("r10_dual_fwd", rf[10], 32'h0F);

    for (int i = 0; i < 16; i++) check("arch_reg", rf[i], mreg[i]);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
